// File: rtl/clkdivbyn_prog.sv
// -----------------------------------------------------------------------------
// clkdivbyn_prog
//   Runtime-programmable clock divider with 50% duty cycle for odd and even
//   divisors. N=1 passes clkin through (bypass), N=0 or en=0 parks the output
//   low. New divisor / enable values are only taken at period boundaries, so
//   the output never shows runt or stretched pulses (except when rstn is
//   asserted, which drops clkout immediately).
//
// Ports
//   clkin       in   source clock (posedge logic plus negedge shaping flops)
//   rstn        in   asynchronous active-low reset
//   en          in   divider run request
//   divbyvalue  in   requested divisor N (DIVW bits)
//   clkout      out  divided clock
//   tick        out  one-clkin-cycle strobe for the cycle clkout rises in
//   div_active  out  divisor currently applied
//   running     out  high while dividing or bypassing
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module clkdivbyn_prog #(
  parameter int DIVW = 4
) (
  input  logic            clkin,
  input  logic            rstn,
  input  logic            en,
  input  logic [DIVW-1:0] divbyvalue,
  output logic            clkout,
  output logic            tick,
  output logic [DIVW-1:0] div_active,
  output logic            running
);

  localparam logic [DIVW-1:0] ZERO = '0;
  localparam logic [DIVW-1:0] ONE  = {{(DIVW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYPASS = 2'd1,
    S_DIVIDE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [DIVW-1:0] div_q, div_d;
  logic            pos_q, pos_d;     // posedge phase flop
  logic            neg_q, neg_d;     // pos_q re-timed on negedge
  logic            byp_q, byp_d;     // negedge-registered bypass gate
  logic            tick_q, tick_d;

  logic            load;
  logic [DIVW-1:0] last_cnt;
  logic [DIVW-1:0] half_lo;

  always_comb begin
    last_cnt = div_q - ONE;
    half_lo  = div_q >> 1;
    // In IDLE every posedge is a load point; otherwise only the last
    // clkin cycle of the current period (always true in BYPASS, N=1).
    load     = (state_q == S_IDLE) || (cnt_q == last_cnt);

    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = (state_q == S_DIVIDE) ? cnt_q + ONE : ZERO;

    if (load) begin
      cnt_d = ZERO;
      if (!en || (divbyvalue == ZERO)) begin
        // div_active keeps the last divisor that was actually run
        state_d = S_IDLE;
      end else begin
        div_d   = divbyvalue;
        state_d = (divbyvalue == ONE) ? S_BYPASS : S_DIVIDE;
      end
    end

    // pos_q lags cnt by one cycle, so clkout rises on the posedge after a
    // load. It is high for floor(N/2) cycles; for odd N the negedge copy
    // stretches the high phase by half a cycle to exactly N/2 while the
    // rising edge stays on a clkin posedge.
    pos_d  = (state_q == S_DIVIDE) && (cnt_q < half_lo);
    tick_d = (state_q == S_BYPASS) || ((state_q == S_DIVIDE) && (cnt_q == ZERO));
    neg_d  = pos_q;
    byp_d  = (state_q == S_BYPASS);
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= ZERO;
      div_q   <= ZERO;
      pos_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pos_q   <= pos_d;
      tick_q  <= tick_d;
    end
  end

  // Negedge flops: odd-divisor shaping and the bypass gate. The gate changes
  // only while clkin is low, so bypass entry and exit give whole pulses.
  always_ff @(negedge clkin or negedge rstn) begin
    if (!rstn) begin
      neg_q <= 1'b0;
      byp_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
      byp_q <= byp_d;
    end
  end

  // neg_q has always fallen before div_q can change (load is at least half a
  // cycle after the high phase ends), so the odd select cannot glitch.
  assign clkout     = (clkin & byp_q) | pos_q | (neg_q & div_q[0]);
  assign tick       = tick_q;
  assign div_active = div_q;
  assign running    = (state_q != S_IDLE);

endmodule

// File: tb/tb_clkdivbyn_prog.sv
`timescale 1ns / 1ps

module tb_clkdivbyn_prog;

  logic       clkin;
  logic       rstn;
  logic       en;
  logic [3:0] divbyvalue;
  logic       clkout;
  logic       tick;
  logic [3:0] div_active;
  logic       running;

  int n_cmp = 0;
  int n_bad = 0;

  clkdivbyn_prog #(.DIVW(4)) dut (
    .clkin      (clkin),
    .rstn       (rstn),
    .en         (en),
    .divbyvalue (divbyvalue),
    .clkout     (clkout),
    .tick       (tick),
    .div_active (div_active),
    .running    (running)
  );

  // 1 ns clock, posedges on integer ns
  initial begin
    clkin = 1'b1;
    forever #0.5 clkin = ~clkin;
  end

  // Half-cycle sampler at 0.25 ns past every edge; hc counts half cycles.
  // Even hc samples are the ones just after a posedge.
  int hc = 0, nrise = 0, last_rise = 0, last_fall = 0;
  int last_per = 0, last_hi = 0, last_ticks = 0, tick_cnt = 0;
  int min_hi = 99, min_lo = 99;
  bit prev_clk = 1'b0, rise_tick = 1'b0;

  initial begin
    #0.25;
    forever begin
      if ((clkout === 1'b1) && !prev_clk) begin
        last_per   = hc - last_rise;
        last_hi    = last_fall - last_rise;
        if (last_hi < min_hi) min_hi = last_hi;
        if ((hc - last_fall) < min_lo) min_lo = hc - last_fall;
        last_ticks = tick_cnt;
        tick_cnt   = 0;
        rise_tick  = (tick === 1'b1);
        last_rise  = hc;
        nrise++;
      end
      if ((clkout !== 1'b1) && prev_clk) last_fall = hc;
      if (((hc % 2) == 0) && (tick === 1'b1)) tick_cnt++;
      prev_clk = (clkout === 1'b1);
      hc++;
      #0.5;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $realtime);
    end
  endtask

  // Wait for k more clkout rises (bounded); returns on a posedge.
  task automatic wait_rises(input int k, input string name);
    int target;
    int cyc;
    target = nrise + k;
    cyc = 0;
    while ((nrise < target) && (cyc < 200)) begin
      @(posedge clkin);
      cyc++;
    end
    chk({name, "_rise_seen"}, int'(nrise >= target), 1);
  endtask

  typedef struct {
    bit       en;
    bit [3:0] n;
    int       hi;    // expected high time, half cycles (0 = idle)
    int       per;   // expected period, half cycles
    bit       run;
    bit [3:0] div;
  } vec_t;

  vec_t vt[9];

  task automatic run_vec(input int i);
    int n0;
    @(negedge clkin);
    en = vt[i].en;
    divbyvalue = vt[i].n;
    if (vt[i].per > 0) begin
      wait_rises(3, $sformatf("v%0d", i));
      chk($sformatf("v%0d_period", i), last_per, vt[i].per);
      chk($sformatf("v%0d_high", i), last_hi, vt[i].hi);
      chk($sformatf("v%0d_ticks", i), last_ticks, 1);
      chk($sformatf("v%0d_tick_at_rise", i), int'(rise_tick), 1);
      #0.25;
      chk($sformatf("v%0d_running", i), int'(running), int'(vt[i].run));
      chk($sformatf("v%0d_div_active", i), int'(div_active), int'(vt[i].div));
    end else begin
      repeat (20) @(posedge clkin);
      n0 = nrise;
      repeat (30) @(posedge clkin);
      #0.25;
      chk($sformatf("v%0d_no_rise", i), nrise, n0);
      chk($sformatf("v%0d_clkout", i), int'(clkout), 0);
      chk($sformatf("v%0d_tick", i), int'(tick), 0);
      chk($sformatf("v%0d_running", i), int'(running), int'(vt[i].run));
      chk($sformatf("v%0d_div_active", i), int'(div_active), int'(vt[i].div));
    end
  endtask

  initial begin
    int n0;
    int cyc;
    //        en  n   hi  per run div
    vt[0] = '{1, 3,  3,  6, 1, 3};
    vt[1] = '{1, 4,  4,  8, 1, 4};
    vt[2] = '{1, 15, 15, 30, 1, 15};
    vt[3] = '{1, 2,  2,  4, 1, 2};
    vt[4] = '{1, 1,  1,  2, 1, 1};   // bypass
    vt[5] = '{1, 0,  0,  0, 0, 1};   // N=0: idle, divisor held
    vt[6] = '{1, 7,  7, 14, 1, 7};
    vt[7] = '{0, 9,  0,  0, 0, 7};   // disabled: N ignored
    vt[8] = '{1, 5,  5, 10, 1, 5};

    rstn = 1'b0;
    en = 1'b1;
    divbyvalue = 4'd3;

    // Reset state
    #10.25;
    chk("rst_clkout", int'(clkout), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_div_active", int'(div_active), 0);
    #10.25;                       // 20.5 ns
    rstn = 1'b1;

    // First load at 21 ns, first clkout rise at 22 ns
    @(posedge clkin); #0.25;
    chk("first_load_clkout", int'(clkout), 0);
    chk("first_load_running", int'(running), 1);
    chk("first_load_tick", int'(tick), 0);
    chk("first_load_div", int'(div_active), 3);
    @(posedge clkin); #0.25;
    chk("first_rise_clkout", int'(clkout), 1);
    chk("first_rise_tick", int'(tick), 1);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Mid-period change 3 -> 5 one cycle after a rise
    @(negedge clkin);
    divbyvalue = 4'd3;
    wait_rises(3, "mid_setup");
    min_hi = 99;
    min_lo = 99;
    @(negedge clkin);
    divbyvalue = 4'd5;
    wait_rises(1, "mid_old");
    chk("mid_old_period", last_per, 6);
    chk("mid_old_high", last_hi, 3);
    wait_rises(1, "mid_new");
    chk("mid_new_period", last_per, 10);
    chk("mid_new_high", last_hi, 5);
    chk("mid_min_high_ge3", int'(min_hi >= 3), 1);
    chk("mid_min_low_ge3", int'(min_lo >= 3), 1);

    // en dropped during the high phase at N=5
    wait_rises(1, "endrop");
    @(negedge clkin);
    en = 1'b0;
    @(posedge clkin);
    @(posedge clkin); #0.25;
    chk("endrop_still_running", int'(running), 1);
    @(posedge clkin); #0.25;
    chk("endrop_idle", int'(running), 0);
    n0 = nrise;
    repeat (20) @(posedge clkin);
    #0.25;
    chk("endrop_no_rise", nrise, n0);
    chk("endrop_full_high", last_fall - last_rise, 5);
    chk("endrop_clkout", int'(clkout), 0);
    chk("endrop_div_hold", int'(div_active), 5);
    @(negedge clkin);
    en = 1'b1;
    wait_rises(2, "reen");
    chk("reen_period", last_per, 10);
    chk("reen_high", last_hi, 5);

    // Reset in the middle of a high phase at N=4
    @(negedge clkin);
    divbyvalue = 4'd4;
    wait_rises(3, "rst_setup");
    #0.25;
    rstn = 1'b0;
    #0.1;
    chk("rst_async_clkout", int'(clkout), 0);
    chk("rst_async_running", int'(running), 0);
    chk("rst_async_div", int'(div_active), 0);
    #60;
    chk("rst_hold_clkout", int'(clkout), 0);
    chk("rst_hold_tick", int'(tick), 0);
    #59.65;
    @(negedge clkin);
    rstn = 1'b1;
    n0 = nrise;
    cyc = 0;
    while ((nrise == n0) && (cyc < 20)) begin
      @(posedge clkin);
      cyc++;
    end
    chk("rst_resume_within_n1", int'(cyc <= 5), 1);
    wait_rises(1, "rst_resume");
    chk("rst_resume_period", last_per, 8);
    chk("rst_resume_high", last_hi, 4);
    chk("rst_resume_div", int'(div_active), 4);

    repeat (20) @(posedge clkin);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
